traffic_fsm: RTL

Phase controller for the two-road intersection. Sequences main-road, side-road and pedestrian phases, drives both light heads and the walk lamp, and is the direct upstream master of the Timer stage. Each phase loads its duration into the Timer through `value`/`start_timer` and advances when the Timer reports `expired`.

---
 rtl/traffic_fsm_pkg.sv | 43 ++++
 rtl/traffic_fsm_req_latch.sv | 21 ++
 rtl/traffic_fsm.sv | 103 ++++++++++
 3 files changed

// File: rtl/traffic_fsm_pkg.sv
// Shared definitions for the intersection phase controller: lamp codes,
// state encodings, default durations and the state-to-lamp mapping.
package traffic_fsm_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_MAIN_G   = 3'd1,
    S_MAIN_Y   = 3'd2,
    S_WALK     = 3'd3,
    S_SIDE_G   = 3'd4,
    S_SIDE_EXT = 3'd5,
    S_SIDE_Y   = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] main_head;
    logic [2:0] side_head;
    logic       walk_lamp;
  } lamps_t;

  function automatic lamps_t lamps_of(input state_t s);
    lamps_t l;
    l = '{main_head: RED, side_head: RED, walk_lamp: 1'b0};
    case (s)
      S_MAIN_G:              l.main_head = GRN;
      S_MAIN_Y:              l.main_head = YEL;
      S_WALK:                l.walk_lamp = 1'b1;
      S_SIDE_G, S_SIDE_EXT:  l.side_head = GRN;
      S_SIDE_Y:              l.side_head = YEL;
      default:               l = '{main_head: RED, side_head: RED, walk_lamp: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_fsm_req_latch.sv
// Sticky request flop: set dominates clear so a request arriving in the
// same cycle as its service is not lost.
module req_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic req_set,
  input  logic req_clr,
  output logic pending
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (req_set) begin
      pending <= 1'b1;
    end else if (req_clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// Two-road intersection phase controller; loads each phase duration into
// the downstream Timer and advances on its expiry.
module traffic_fsm
  import traffic_fsm_pkg::*;
#(
  parameter int T_BASE = DEF_T_BASE,
  parameter int T_EXT  = DEF_T_EXT,
  parameter int T_YEL  = DEF_T_YEL
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic [3:0] value,
  output logic       start_timer,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk
);

  if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 ||
      T_YEL < 1 || T_YEL > 15) begin : g_bad_duration
    $error("traffic_fsm: duration parameters must lie in 1..15");
  end

  localparam logic [3:0] V_BASE = 4'(T_BASE);
  localparam logic [3:0] V_EXT  = 4'(T_EXT);
  localparam logic [3:0] V_YEL  = 4'(T_YEL);

  state_t     state;
  state_t     state_next;
  logic       armed;
  logic       take;
  logic [3:0] load_value;
  logic       walk_pending;
  logic       walk_clr;
  lamps_t     lamps_next;

  req_latch u_walk_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .req_set (walk_request),
    .req_clr (walk_clr),
    .pending (walk_pending)
  );

  always_comb begin
    state_next = state;
    take       = 1'b0;
    if (state == S_INIT) begin
      take       = 1'b1;
      state_next = S_MAIN_G;
    end else if (armed && expired) begin
      take = 1'b1;
      case (state)
        S_MAIN_G:   state_next = (sensor || walk_pending) ? S_MAIN_Y : S_MAIN_G;
        S_MAIN_Y:   state_next = walk_pending ? S_WALK : S_SIDE_G;
        S_WALK:     state_next = sensor ? S_SIDE_G : S_MAIN_G;
        S_SIDE_G:   state_next = sensor ? S_SIDE_EXT : S_SIDE_Y;
        S_SIDE_EXT: state_next = S_SIDE_Y;
        S_SIDE_Y:   state_next = S_MAIN_G;
        default:    state_next = S_INIT;
      endcase
    end
  end

  always_comb begin
    load_value = V_BASE;
    case (state_next)
      S_MAIN_Y, S_SIDE_Y:   load_value = V_YEL;
      S_WALK, S_SIDE_EXT:   load_value = V_EXT;
      default:              load_value = V_BASE;
    endcase
  end

  assign walk_clr   = take && (state_next == S_WALK);
  assign lamps_next = lamps_of(state_next);

  // armed drops during the start_timer cycle so a stale expired is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT;
      armed       <= 1'b0;
      start_timer <= 1'b0;
      value       <= 4'd0;
      main_lights <= RED;
      side_lights <= RED;
      walk        <= 1'b0;
    end else begin
      state       <= state_next;
      armed       <= !take;
      start_timer <= take;
      if (take) begin
        value <= load_value;
      end
      main_lights <= lamps_next.main_head;
      side_lights <= lamps_next.side_head;
      walk        <= lamps_next.walk_lamp;
    end
  end

endmodule
